// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle controller and memory.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch, decode, exec, mem, writeback, trap.
// Moore outputs are registered from next state; rst gates every output.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic                     br_taken,
  multicycle_ctrl_if.master        bus,
  output logic                     ir_we,
  output logic                     reg_we,
  output logic                     alu_src_a,
  output logic                     alu_src_b,
  output logic [1:0]               wb_sel,
  output logic                     pc_we,
  output logic [1:0]               pc_sel,
  output logic                     instr_done,
  output logic                     trap,
  output logic [1:0]               trap_cause
);

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LD,
    C_ST,
    C_BR,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC
  } cls_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       reg_we;
    logic       src_a;
    logic       src_b;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       done;
    logic       br;
    logic       trap;
    logic [1:0] cause;
  } mo_t;

  state_t     st, st_n;
  cls_t       cls, cls_n, dec_cls;
  logic       dec_ok;
  logic [1:0] cause, cause_n;
  logic [7:0] wcnt, wcnt_n;
  logic       wait_hit;
  logic       mem_hs;
  logic       st_done;
  logic [6:0] op;
  logic       unused_bits;
  mo_t        mo_q;

  assign op          = instr[6:0];
  assign unused_bits = ^instr[31:7];

  function automatic mo_t moore(state_t s, cls_t c, logic [1:0] tc);
    mo_t o;
    o = '0;
    unique case (s)
      S_FETCH: o.mem_req = 1'b1;
      S_EXEC: begin
        o.src_a = c inside {C_AUIPC, C_JAL, C_BR};
        o.src_b = !(c inside {C_R, C_BR});
        if (c == C_BR) begin
          o.pc_we = 1'b1;
          o.done  = 1'b1;
          o.br    = 1'b1;
        end
      end
      S_MEM: begin
        o.mem_req = 1'b1;
        o.mem_we  = (c == C_ST);
      end
      S_WB: begin
        o.reg_we = 1'b1;
        o.pc_we  = 1'b1;
        o.done   = 1'b1;
        if (c == C_LD)
          o.wb_sel = 2'd1;
        else if (c == C_JAL || c == C_JALR)
          o.wb_sel = 2'd2;
        if (c == C_JAL)
          o.pc_sel = 2'd1;
        else if (c == C_JALR)
          o.pc_sel = 2'd2;
      end
      S_TRAP: begin
        o.trap  = 1'b1;
        o.cause = tc;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b1;
    unique case (1'b1)
      (op == 7'b0110011): dec_cls = C_R;
      (op == 7'b0010011): dec_cls = C_I;
      (op == 7'b0000011): dec_cls = C_LD;
      (op == 7'b0100011): dec_cls = C_ST;
      (op == 7'b1100011): dec_cls = C_BR;
      (op == 7'b1101111): dec_cls = C_JAL;
      (op == 7'b1100111): dec_cls = C_JALR;
      (op == 7'b0110111): dec_cls = C_LUI;
      (op == 7'b0010111): dec_cls = C_AUIPC;
      default:            dec_ok  = 1'b0;
    endcase
  end

  // Wait trips when this stalled cycle would bring the count to TIMEOUT.
  assign wait_hit = (wcnt == TLIM);

  always_comb begin
    st_n    = st;
    cls_n   = cls;
    cause_n = cause;
    wcnt_n  = wcnt;
    unique case (st)
      S_FETCH: begin
        if (bus.mem_ready) begin
          st_n = S_DECODE;
        end else if (wait_hit) begin
          st_n    = S_TRAP;
          cause_n = 2'b10;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          st_n  = S_EXEC;
          cls_n = dec_cls;
        end else begin
          st_n    = S_TRAP;
          cause_n = 2'b01;
        end
      end
      S_EXEC: begin
        if (cls == C_BR)
          st_n = S_FETCH;
        else if (cls == C_LD || cls == C_ST)
          st_n = S_MEM;
        else
          st_n = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          st_n = (cls == C_ST) ? S_FETCH : S_WB;
        end else if (wait_hit) begin
          st_n    = S_TRAP;
          cause_n = 2'b10;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end
      S_WB:    st_n = S_FETCH;
      S_TRAP:  st_n = S_TRAP;
      default: st_n = S_FETCH;
    endcase
    if (st_n != st && (st_n == S_FETCH || st_n == S_MEM))
      wcnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= S_FETCH;
      cls   <= C_R;
      cause <= 2'b00;
      wcnt  <= '0;
      mo_q  <= moore(S_FETCH, C_R, 2'b00);
    end else begin
      st    <= st_n;
      cls   <= cls_n;
      cause <= cause_n;
      wcnt  <= wcnt_n;
      mo_q  <= moore(st_n, cls_n, cause_n);
    end
  end

  // Only a store retires on the memory handshake itself.
  assign mem_hs  = (st == S_MEM) && bus.mem_ready;
  assign st_done = mem_hs && (cls == C_ST);

  assign bus.mem_req = !rst && mo_q.mem_req;
  assign bus.mem_we  = !rst && mo_q.mem_we;
  assign ir_we       = !rst && (st == S_FETCH) && bus.mem_ready;
  assign reg_we      = !rst && mo_q.reg_we;
  assign alu_src_a   = !rst && mo_q.src_a;
  assign alu_src_b   = !rst && mo_q.src_b;
  assign wb_sel      = rst ? 2'd0 : mo_q.wb_sel;
  assign pc_we       = !rst && (mo_q.pc_we || st_done);
  assign instr_done  = !rst && (mo_q.done || st_done);
  assign trap        = !rst && mo_q.trap;
  assign trap_cause  = rst ? 2'd0 : mo_q.cause;

  always_comb begin
    pc_sel = 2'd0;
    if (!rst)
      pc_sel = mo_q.br ? {1'b0, br_taken} : mo_q.pc_sel;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with TIMEOUT=4.
// Outputs are packed into one vector and compared per cycle.
module tb_multicycle_ctrl;

  localparam logic [14:0] NONE  = 15'h0000;
  localparam logic [14:0] MREQ  = 15'h4000;
  localparam logic [14:0] MWE   = 15'h2000;
  localparam logic [14:0] IRWE  = 15'h1000;
  localparam logic [14:0] REGWE = 15'h0800;
  localparam logic [14:0] SA    = 15'h0400;
  localparam logic [14:0] SB    = 15'h0200;
  localparam logic [14:0] WB2   = 15'h0100;
  localparam logic [14:0] WB1   = 15'h0080;
  localparam logic [14:0] PCWE  = 15'h0040;
  localparam logic [14:0] PS2   = 15'h0020;
  localparam logic [14:0] PS1   = 15'h0010;
  localparam logic [14:0] DONE  = 15'h0008;
  localparam logic [14:0] TRAP  = 15'h0004;
  localparam logic [14:0] C2    = 15'h0002;
  localparam logic [14:0] C1    = 15'h0001;
  localparam logic [14:0] MI    = MREQ | IRWE;
  localparam logic [14:0] RET   = REGWE | PCWE | DONE;

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'h00052283;
  localparam logic [31:0] SW    = 32'h00112023;
  localparam logic [31:0] BEQ   = 32'hFE000EE3;
  localparam logic [31:0] JAL   = 32'h0000006F;
  localparam logic [31:0] JALR  = 32'h00008067;
  localparam logic [31:0] LUI   = 32'h000012B7;
  localparam logic [31:0] AUIPC = 32'h00001297;
  localparam logic [31:0] ADD   = 32'h002081B3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = ADDI;
  logic        br_taken = 1'b0;
  logic        ir_we, reg_we, alu_src_a, alu_src_b;
  logic [1:0]  wb_sel, pc_sel, trap_cause;
  logic        pc_we, instr_done, trap;
  logic [14:0] ov;
  int          tests = 0;
  int          fails = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .br_taken   (br_taken),
    .bus        (bus),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .wb_sel     (wb_sel),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  assign ov = {bus.mem_req, bus.mem_we, ir_we, reg_we, alu_src_a,
               alu_src_b, wb_sel, pc_we, pc_sel, instr_done, trap,
               trap_cause};

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    br_taken = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    br_taken = 1'b1;
    instr = ADDI;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ov !== NONE) begin
      fails++;
      $display("FAIL reset_outs got %h want %h", ov, NONE);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ov !== MI) begin
      fails++;
      $display("FAIL reset_release got %h want %h", ov, MI);
    end
  endtask

  task automatic test_addi();
    logic [14:0] ex [5];
    ex = '{MI, NONE, SB, RET, MI};
    do_reset();
    instr = ADDI;
    for (int c = 0; c < 5; c++) begin
      bus.mem_ready = 1'b1;
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL addi c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alu_classes();
    logic [31:0] ins [3];
    logic [14:0] exe [3];
    ins = '{ADD, LUI, AUIPC};
    exe = '{NONE, SB, SA | SB};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      instr = ins[k];
      bus.mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1;
        tests++;
        if (ov !== (c == 2 ? exe[k] : c == 3 ? RET :
                    c == 1 ? NONE : MI)) begin
          fails++;
          $display("FAIL alu%0d c%0d got %h", k, c, ov);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_load();
    logic [14:0] ex [9];
    logic        rdy [9];
    ex  = '{MI, NONE, SB, MREQ, MREQ, MREQ, MREQ,
            RET | WB1, MI};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
            1'b1, 1'b1};
    do_reset();
    instr = LW;
    for (int c = 0; c < 9; c++) begin
      bus.mem_ready = rdy[c];
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL load c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store();
    logic [14:0] ex [6];
    logic        rdy [6];
    ex  = '{MI, NONE, SB, MREQ | MWE,
            MREQ | MWE | PCWE | DONE, MI};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    instr = SW;
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = rdy[c];
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL store c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    logic [14:0] ex [7];
    logic        br [7];
    ex = '{MI, NONE, SA | PCWE | PS1 | DONE, MI, NONE,
           SA | PCWE | DONE, MI};
    br = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    instr = BEQ;
    for (int c = 0; c < 7; c++) begin
      bus.mem_ready = 1'b1;
      br_taken = br[c];
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL branch c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
    br_taken = 1'b0;
  endtask

  task automatic test_jump();
    logic [31:0] ins [2];
    logic [14:0] exe [2];
    logic [14:0] exw [2];
    ins = '{JAL, JALR};
    exe = '{SA | SB, SB};
    exw = '{RET | WB2 | PS1, RET | WB2 | PS2};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      instr = ins[k];
      bus.mem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1;
        tests++;
        if (ov !== (c == 2 ? exe[k] : c == 3 ? exw[k] :
                    c == 1 ? NONE : MI)) begin
          fails++;
          $display("FAIL jump%0d c%0d got %h", k, c, ov);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    instr = 32'hFFFFFFFF;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      #1;
      tests++;
      if (ov !== (c == 0 ? MI : c == 1 ? NONE : TRAP | C1)) begin
        fails++;
        $display("FAIL illegal c%0d got %h", c, ov);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ov !== NONE) begin
      fails++;
      $display("FAIL trap_rst got %h want %h", ov, NONE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (ov !== MI) begin
      fails++;
      $display("FAIL trap_release got %h want %h", ov, MI);
    end
  endtask

  task automatic test_timeout();
    logic [14:0] ex [6];
    logic        rdy [6];
    ex  = '{MREQ, MREQ, MREQ, MREQ, TRAP | C2, TRAP | C2};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    instr = ADDI;
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = rdy[c];
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL tmo c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
    ex  = '{MREQ, MREQ, MREQ, MI, NONE, SB};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = rdy[c];
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL tmo_win c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mem_timeout();
    logic [14:0] ex [8];
    logic        rdy [8];
    ex  = '{MI, NONE, SB, MREQ, MREQ, MREQ, MREQ, TRAP | C2};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    instr = LW;
    for (int c = 0; c < 8; c++) begin
      bus.mem_ready = rdy[c];
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL mem_tmo c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] ex [9];
    ex = '{MI, NONE, SB, RET, MI, NONE, SB,
           MREQ | MWE | PCWE | DONE, MI};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      instr = (c < 4) ? ADDI : SW;
      #1;
      tests++;
      if (ov !== ex[c]) begin
        fails++;
        $display("FAIL b2b c%0d got %h want %h", c, ov, ex[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    instr = LW;
    for (int c = 0; c < 4; c++) begin
      bus.mem_ready = (c < 3);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    tests++;
    if (ov !== NONE) begin
      fails++;
      $display("FAIL midop_rst got %h want %h", ov, NONE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (ov !== MI) begin
      fails++;
      $display("FAIL midop_release got %h want %h", ov, MI);
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_alu_classes();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_mem_timeout();
    test_back_to_back();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
